grid_dump_tx: RTL and testbench

GRID_DUMP_TX -- requirements
Module: grid_dump_tx

---
 rtl/grid_dump_tx.sv | 141 ++++++++++++++
 tb/tb_grid_dump_tx.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_dump_tx.sv
// Streams a ROWS x COLS cell grid as ASCII text over a valid/ready byte port:
// a CR/LF header, then one line per row (cell characters followed by CR/LF).
module grid_dump_tx #(
  parameter int         ROWS     = 32,
  parameter int         COLS     = 8,
  parameter logic [7:0] CH_ALIVE = 8'h23,
  parameter logic [7:0] CH_DEAD  = 8'h2E
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [4:0]      row_sel,
  input  logic [COLS-1:0] row_data,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            busy,
  output logic            done
);

  localparam int              CW       = $clog2(COLS) + 1;
  localparam int              IW       = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0]   COL_LAST = CW'(COLS - 1);
  localparam logic [4:0]      ROW_LAST = 5'(ROWS - 1);
  localparam logic [7:0]      ASCII_CR = 8'h0D;
  localparam logic [7:0]      ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    HDR_CR,
    HDR_LF,
    LATCH,
    CELL,
    ROW_CR,
    ROW_LF
  } state_t;

  state_t          state, state_next;
  logic [COLS-1:0] row_reg;
  logic [CW-1:0]   col, col_next;
  logic [4:0]      row_sel_next;
  logic            load_row;
  logic            done_next;

  // Byte outputs are decoded from the registered state, so they cannot
  // change while a byte is stalled waiting for tx_ready.
  always_comb begin
    // NOTE: every output of this block gets a default first; any path that
    // skipped an assignment would otherwise infer a latch.
    state_next   = state;
    row_sel_next = row_sel;
    col_next     = col;
    load_row     = 1'b0;
    done_next    = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = '0;

    case (state)
      IDLE: begin
        if (start) begin
          row_sel_next = '0;
          state_next   = HDR_CR;
        end
      end

      HDR_CR: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_CR;
        if (tx_ready) state_next = HDR_LF;
      end

      HDR_LF: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_LF;
        if (tx_ready) state_next = LATCH;
      end

      // Quiet cycle: row_sel has settled for a full cycle before capture.
      LATCH: begin
        load_row   = 1'b1;
        col_next   = '0;
        state_next = CELL;
      end

      CELL: begin
        tx_valid = 1'b1;
        tx_data  = row_reg[col[IW-1:0]] ? CH_ALIVE : CH_DEAD;
        if (tx_ready) begin
          if (col == COL_LAST) state_next = ROW_CR;
          else                 col_next   = col + 1'b1;
        end
      end

      ROW_CR: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_CR;
        if (tx_ready) state_next = ROW_LF;
      end

      ROW_LF: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_LF;
        if (tx_ready) begin
          if (row_sel == ROW_LAST) begin
            row_sel_next = '0;
            done_next    = 1'b1;
            state_next   = IDLE;
          end else begin
            row_sel_next = row_sel + 1'b1;
            state_next   = LATCH;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      row_sel <= '0;
      col     <= '0;
      // NOTE: the row register is a plain flop bank, so it is cleared with
      // everything else; a RAM-style store would not be reset.
      row_reg <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      row_sel <= row_sel_next;
      col     <= col_next;
      done    <= done_next;
      if (load_row) row_reg <= row_data;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_grid_dump_tx.sv
// Self-checking bench for grid_dump_tx: captures the accepted byte stream and
// compares it with a frame built directly from the grid contents.
module tb_grid_dump_tx;

  localparam int ROWS  = 32;
  localparam int COLS  = 8;
  localparam int FRAME = 2 + ROWS * (COLS + 2);

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [4:0]      row_sel;
  logic [COLS-1:0] row_data;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic            busy;
  logic            done;

  logic [COLS-1:0] rows_tbl [ROWS];
  logic [COLS-1:0] snap     [ROWS];
  logic [7:0]      got_bytes[$];
  int              got_cycles[$];
  logic [7:0]      exp_bytes[$];
  int              done_cycle;
  int              stall_err;
  int              stall_cnt;
  logic            busy_at_done;
  int              tests_run = 0;
  int              failed    = 0;

  always #5 clk = ~clk;

  assign row_data = rows_tbl[row_sel];

  grid_dump_tx dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .row_sel  (row_sel),
    .row_data (row_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  // Reference frame: header CR LF, then per row the cell characters and CR LF.
  task automatic build_expected();
    exp_bytes.delete();
    exp_bytes.push_back(8'h0D);
    exp_bytes.push_back(8'h0A);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) exp_bytes.push_back(snap[r][c] ? 8'h23 : 8'h2E);
      exp_bytes.push_back(8'h0D);
      exp_bytes.push_back(8'h0A);
    end
  endtask

  function automatic int first_diff();
    for (int i = 0; i < exp_bytes.size(); i++)
      if (i >= got_bytes.size() || got_bytes[i] !== exp_bytes[i]) return i;
    if (got_bytes.size() != exp_bytes.size()) return exp_bytes.size();
    return -1;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < got_cycles.size()) ? got_cycles[i] : -1;
  endfunction

  function automatic logic [7:0] byte_at(input int i);
    return (i < got_bytes.size()) ? got_bytes[i] : 8'hxx;
  endfunction

  // mode: 0 ready=1, 1 random ready, 2 20-cycle stall on row 5 cell 3,
  //       3 ready=1 with row data flipped mid-row.
  // start_mode: 0 single pulse, 1 extra pulse at cycle 100, 2 held high.
  task automatic run_frame(input int mode, input int start_mode, input int budget);
    logic [7:0] held        = 8'h00;
    logic       was_stalled = 1'b0;
    got_bytes.delete();
    got_cycles.delete();
    done_cycle   = -1;
    stall_err    = 0;
    stall_cnt    = 0;
    busy_at_done = 1'b1;
    for (int r = 0; r < ROWS; r++) snap[r] = rows_tbl[r];
    build_expected();
    start    = 1'b1;
    tx_ready = 1'b1;
    for (int c = 1; c <= budget && done_cycle < 0; c++) begin
      @(negedge clk);
      start = (start_mode == 2) || (start_mode == 1 && c == 100);
      case (mode)
        1:       tx_ready = 1'($urandom_range(0, 1));
        2:       tx_ready = !(got_bytes.size() == 55 && tx_valid && stall_cnt < 20);
        default: tx_ready = 1'b1;
      endcase
      if (mode == 2 && !tx_ready) stall_cnt++;
      if (mode == 3 && got_bytes.size() > 2 && (got_bytes.size() - 2) % 10 == 3)
        rows_tbl[row_sel] = ~rows_tbl[row_sel];
      if (was_stalled && (tx_valid !== 1'b1 || tx_data !== held)) stall_err++;
      if (tx_valid && tx_ready) begin
        got_bytes.push_back(tx_data);
        got_cycles.push_back(c);
      end
      was_stalled = tx_valid && !tx_ready;
      held        = tx_data;
      if (done) begin
        done_cycle   = c;
        busy_at_done = busy;
      end
    end
    if (start_mode != 2) start = 1'b0;
    if (mode == 3) for (int r = 0; r < ROWS; r++) rows_tbl[r] = snap[r];
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failed++;
      $display("FAIL reset_ctrl valid/busy/done=%b%b%b expected 000", tx_valid, busy, done);
    end
    tests_run++;
    if (row_sel !== 5'd0 || tx_data !== 8'h00) begin
      failed++;
      $display("FAIL reset_data row_sel=%0d tx_data=%h expected 0/00", row_sel, tx_data);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      failed++;
      $display("FAIL reset_priority busy=%b tx_valid=%b expected 0/0", busy, tx_valid);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int d;
    int bad_lf = 0;
    for (int r = 0; r < ROWS; r++) rows_tbl[r] = 8'h01;
    run_frame(0, 0, 500);
    d = first_diff();
    tests_run++;
    if (got_bytes.size() != FRAME) begin
      failed++;
      $display("FAIL basic_len got=%0d expected=%0d", got_bytes.size(), FRAME);
    end
    tests_run++;
    if (d != -1) begin
      failed++;
      $display("FAIL basic_stream first_diff=%0d expected -1", d);
    end
    tests_run++;
    if (cyc_at(0) != 1 || byte_at(0) !== 8'h0D || cyc_at(1) != 2 || byte_at(1) !== 8'h0A) begin
      failed++;
      $display("FAIL basic_header cycles=%0d,%0d bytes=%h,%h expected 1,2 0d,0a",
               cyc_at(0), cyc_at(1), byte_at(0), byte_at(1));
    end
    tests_run++;
    if (cyc_at(2) != 4 || cyc_at(9) != 11 || byte_at(2) !== 8'h23 ||
        byte_at(3) !== 8'h2E || byte_at(9) !== 8'h2E) begin
      failed++;
      $display("FAIL basic_row0 cycles=%0d..%0d bytes=%h,%h,%h expected 4..11 23,2e,2e",
               cyc_at(2), cyc_at(9), byte_at(2), byte_at(3), byte_at(9));
    end
    for (int k = 0; k < ROWS; k++)
      if (cyc_at(11 + 10 * k) != 2 + 11 * (k + 1) || byte_at(11 + 10 * k) !== 8'h0A) bad_lf++;
    tests_run++;
    if (bad_lf != 0) begin
      failed++;
      $display("FAIL basic_row_lf_timing bad_rows=%0d expected 0", bad_lf);
    end
    tests_run++;
    if (done_cycle != 355 || busy_at_done !== 1'b0) begin
      failed++;
      $display("FAIL basic_done cycle=%0d busy=%b expected 355 busy=0", done_cycle, busy_at_done);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
      failed++;
      $display("FAIL basic_after_done done/busy/valid=%b%b%b expected 000", done, busy, tx_valid);
    end
  endtask

  task automatic test_random_ready();
    int d;
    for (int pass = 0; pass < 2; pass++) begin
      for (int r = 0; r < ROWS; r++)
        rows_tbl[r] = (pass == 0) ? COLS'(r) : COLS'($urandom);
      run_frame(1, 0, 3000);
      d = first_diff();
      tests_run++;
      if (d != -1 || done_cycle < 0) begin
        failed++;
        $display("FAIL random_stream pass=%0d first_diff=%0d done_cycle=%0d expected -1/done",
                 pass, d, done_cycle);
      end
      tests_run++;
      if (stall_err != 0) begin
        failed++;
        $display("FAIL random_stall_hold pass=%0d violations=%0d expected 0", pass, stall_err);
      end
    end
  endtask

  task automatic test_stall();
    int d;
    for (int r = 0; r < ROWS; r++) rows_tbl[r] = COLS'($urandom);
    run_frame(2, 0, 1000);
    d = first_diff();
    tests_run++;
    if (stall_cnt != 20 || stall_err != 0) begin
      failed++;
      $display("FAIL stall_hold stall_cycles=%0d violations=%0d expected 20/0", stall_cnt, stall_err);
    end
    tests_run++;
    if (d != -1 || done_cycle != 375) begin
      failed++;
      $display("FAIL stall_resume first_diff=%0d done_cycle=%0d expected -1/375", d, done_cycle);
    end
  endtask

  task automatic test_start_ignored();
    int d;
    for (int r = 0; r < ROWS; r++) rows_tbl[r] = COLS'($urandom);
    run_frame(0, 1, 500);
    d = first_diff();
    tests_run++;
    if (d != -1 || done_cycle != 355) begin
      failed++;
      $display("FAIL start_pulse_mid first_diff=%0d done_cycle=%0d expected -1/355", d, done_cycle);
    end
    @(negedge clk);
    tests_run++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL start_pulse_no_requeue valid=%b busy=%b expected 0/0", tx_valid, busy);
    end
    run_frame(0, 2, 500);
    d = first_diff();
    tests_run++;
    if (d != -1 || done_cycle != 355) begin
      failed++;
      $display("FAIL start_held first_diff=%0d done_cycle=%0d expected -1/355", d, done_cycle);
    end
    @(negedge clk);
    tests_run++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h0D || busy !== 1'b1) begin
      failed++;
      $display("FAIL start_held_restart valid=%b data=%h busy=%b expected 1/0d/1",
               tx_valid, tx_data, busy);
    end
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int d;
    int hit   = 0;
    int leaks = 0;
    for (int r = 0; r < ROWS; r++) rows_tbl[r] = COLS'($urandom);
    start = 1'b1; tx_ready = 1'b1;
    for (int c = 0; c < 400 && hit == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (row_sel == 5'd10 && tx_valid) hit = 1;
    end
    tests_run++;
    if (hit == 0) begin
      failed++;
      $display("FAIL reset_mid_reach_row10 row_sel=%0d expected 10 within budget", row_sel);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || row_sel !== 5'd0 || done !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_abort valid=%b busy=%b row_sel=%0d done=%b expected 0/0/0/0",
               tx_valid, busy, row_sel, done);
    end
    repeat (10) begin
      @(negedge clk);
      if (tx_valid) leaks++;
    end
    tests_run++;
    if (leaks != 0) begin
      failed++;
      $display("FAIL reset_mid_quiet valid_cycles=%0d expected 0", leaks);
    end
    run_frame(0, 0, 500);
    d = first_diff();
    tests_run++;
    if (d != -1 || got_bytes.size() != FRAME || done_cycle != 355) begin
      failed++;
      $display("FAIL reset_mid_refresh first_diff=%0d len=%0d done_cycle=%0d expected -1/%0d/355",
               d, got_bytes.size(), done_cycle, FRAME);
    end
  endtask

  task automatic test_latch_isolation();
    int d;
    for (int r = 0; r < ROWS; r++) rows_tbl[r] = COLS'($urandom);
    run_frame(3, 0, 500);
    d = first_diff();
    tests_run++;
    if (d != -1 || got_bytes.size() != FRAME) begin
      failed++;
      $display("FAIL latch_isolation first_diff=%0d len=%0d expected -1/%0d",
               d, got_bytes.size(), FRAME);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tx_ready = 1'b0;
    for (int r = 0; r < ROWS; r++) rows_tbl[r] = '0;
    test_reset();
    test_basic();
    test_random_ready();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_latch_isolation();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout simulation exceeded 1 ms");
    $fatal(1, "timeout");
  end

endmodule
